// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmit sequencer.
package serial_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned BIT_CNT_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    PARITY
  } state_t;

endpackage

// File: rtl/bit_timer.sv
// Per-bit tick counter: counts 0..CLKS_PER_BIT-1, wraps on its own, held at 0 by clear.
module bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic last_tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] cnt;

  assign last_tick = (cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clear || last_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_tx_ctrl.sv
// Frames bytes as async serial by sequencing an external load/shift-right register.
// Optional parity bit between data and stop: define SERIAL_TX_PARITY_EN.
module serial_tx_ctrl
  import serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned ODD_PARITY   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  input  logic [7:0] sr_q,
  output logic       sr_sl,
  output logic [7:0] sr_pin,
  output logic       sr_sin,
  output logic       txd,
  output logic       busy,
  output logic       done
);

  if (CLKS_PER_BIT < 2 || (STOP_BITS != 1 && STOP_BITS != 2) || ODD_PARITY > 1) begin : g_bad_params
    $error("serial_tx_ctrl: illegal parameter combination");
  end

  state_t               state;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 last_tick;
  logic                 stop_end;
  logic                 accept;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state == IDLE),
    .last_tick(last_tick)
  );

  assign stop_end  = (state == STOP) && last_tick && (bit_cnt == BIT_CNT_W'(STOP_BITS - 1));
  assign din_ready = rst_n && ((state == IDLE) || stop_end);
  assign accept    = din_valid && din_ready;
  assign busy      = (state != IDLE);
  assign done      = stop_end;
  assign sr_sin    = 1'b1;

`ifdef SERIAL_TX_PARITY_EN
  logic parity_bit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity_bit <= 1'b0;
    end else if (accept) begin
      parity_bit <= (^din) ^ ODD_PARITY[0];
    end
  end
`endif

  // The register has no hold mode: recirculate Q unless loading or shifting.
  always_comb begin
    sr_sl  = 1'b1;
    sr_pin = sr_q;
    if (!rst_n) begin
      sr_pin = 8'hFF;
    end else if (accept) begin
      sr_pin = din;
    end else if ((state == DATA) && last_tick) begin
      sr_sl = 1'b0;
    end
  end

  always_comb begin
    txd = 1'b1;
    case (state)
      START:   txd = 1'b0;
      DATA:    txd = sr_q[0];
`ifdef SERIAL_TX_PARITY_EN
      PARITY:  txd = parity_bit;
`endif
      default: txd = 1'b1;
    endcase
  end

  // Every transition out of a non-IDLE state lands on a last tick, so the timer wraps in step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) state <= START;
        end
        START: begin
          if (last_tick) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (last_tick) begin
            if (bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) begin
`ifdef SERIAL_TX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        PARITY: begin
          if (last_tick) begin
            state   <= STOP;
            bit_cnt <= '0;
          end
        end
`endif
        STOP: begin
          if (last_tick) begin
            if (stop_end) begin
              state   <= accept ? START : IDLE;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_ctrl.sv
// Bench for serial_tx_ctrl: two instances (1 and 2 stop bits) each driving a modelled shift register.
module tb_serial_tx_ctrl;

  localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din       [2];
  logic       din_valid [2];
  logic       din_ready [2];
  logic [7:0] sr_q      [2];
  logic       sr_sl     [2];
  logic [7:0] sr_pin    [2];
  logic       sr_sin    [2];
  logic       txd       [2];
  logic       busy      [2];
  logic       done      [2];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // External 8-bit load / shift-right register, one per instance.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      sr_q[k] <= sr_sl[k] ? sr_pin[k] : {sr_sin[k], sr_q[k][7:1]};
    end
  end

  serial_tx_ctrl #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .ODD_PARITY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .din(din[0]), .din_valid(din_valid[0]), .din_ready(din_ready[0]),
    .sr_q(sr_q[0]), .sr_sl(sr_sl[0]), .sr_pin(sr_pin[0]), .sr_sin(sr_sin[0]),
    .txd(txd[0]), .busy(busy[0]), .done(done[0])
  );

  serial_tx_ctrl #(.CLKS_PER_BIT(CPB), .STOP_BITS(2), .ODD_PARITY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .din(din[1]), .din_valid(din_valid[1]), .din_ready(din_ready[1]),
    .sr_q(sr_q[1]), .sr_sl(sr_sl[1]), .sr_pin(sr_pin[1]), .sr_sin(sr_sin[1]),
    .txd(txd[1]), .busy(busy[1]), .done(done[1])
  );

  task automatic chk(input string tag, input int d, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s[dut%0d] at %0t: observed %0h expected %0h", tag, d, $time, obs, exp);
    end
  endtask

  function automatic int stop_bits(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic int frame_len(input int d);
    return (10 + PAR + stop_bits(d) - 1) * CPB;
  endfunction

  // Instance 0 uses even parity, instance 1 odd.
  function automatic logic parity_of(input int d, input logic [7:0] b);
    return (d == 1) ? ~(^b) : ^b;
  endfunction

  // Expected line level in cycle c (1-based) after the acceptance edge.
  function automatic logic exp_txd(input int d, input logic [7:0] b, input int c);
    int k;
    k = (c - 1) / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (PAR == 1 && k == 9) return parity_of(d, b);
    return 1'b1;
  endfunction

  // Expected register contents: byte shifted right once per finished data bit, ones shifted in.
  function automatic logic [7:0] exp_sr(input logic [7:0] b, input int c);
    int          k;
    logic [15:0] w;
    k = (c - 1) / CPB;
    w = {8'hFF, b};
    if (k == 0) return b;
    if (k <= 8) return 8'(w >> (k - 1));
    return 8'hFF;
  endfunction

  // One frame: present b (unless already accepted), then check every cycle up to the last stop cycle.
  task automatic frame(input int d, input logic [7:0] b, input int hold, input bit chain,
                       input logic [7:0] nb, input bit pre, input int abort_at);
    int len;
    len = frame_len(d);
    if (!pre) begin
      @(negedge clk);
      chk("ready_idle", d, 8'(din_ready[d]), 8'd1);
      din[d]       = b;
      din_valid[d] = 1'b1;
    end
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      if (c == abort_at) return;
      chk("txd",   d, 8'(txd[d]),       8'(exp_txd(d, b, c)));
      chk("busy",  d, 8'(busy[d]),      8'd1);
      chk("done",  d, 8'(done[d]),      8'(c == len));
      chk("ready", d, 8'(din_ready[d]), 8'(c == len));
      chk("sr_q",  d, sr_q[d],          exp_sr(b, c));
      if (c == 1) begin
        if (chain) din[d] = nb;
        else if (hold > 0) din[d] = 8'h55;
      end
      if (!chain && c == hold + 1) din_valid[d] = 1'b0;
    end
  endtask

  task automatic idle(input int d, input int n);
    repeat (n) begin
      @(negedge clk);
      chk("idle_txd",   d, 8'(txd[d]),       8'd1);
      chk("idle_busy",  d, 8'(busy[d]),      8'd0);
      chk("idle_done",  d, 8'(done[d]),      8'd0);
      chk("idle_ready", d, 8'(din_ready[d]), 8'd1);
      chk("idle_sl",    d, 8'(sr_sl[d]),     8'd1);
      chk("idle_sin",   d, 8'(sr_sin[d]),    8'd1);
      chk("idle_sr_q",  d, sr_q[d],          8'hFF);
    end
  endtask

  initial begin
    bit         pre;
    bit         ch;
    logic [7:0] b;
    logic [7:0] nb;
    int         hold;

    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      din[k]       = 8'h00;
      din_valid[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_txd",   d, 8'(txd[d]),       8'd1);
      chk("rst_busy",  d, 8'(busy[d]),      8'd0);
      chk("rst_done",  d, 8'(done[d]),      8'd0);
      chk("rst_ready", d, 8'(din_ready[d]), 8'd0);
      chk("rst_sl",    d, 8'(sr_sl[d]),     8'd1);
      chk("rst_pin",   d, sr_pin[d],        8'hFF);
      chk("rst_sr_q",  d, sr_q[d],          8'hFF);
    end
    rst_n = 1'b1;
    idle(0, 2);
    idle(1, 1);

    // Single frame, then hold after a load.
    frame(0, 8'hA5, 0, 1'b0, 8'h00, 1'b0, 0);
    idle(0, 1);
    frame(0, 8'h3C, 0, 1'b0, 8'h00, 1'b0, 0);
    idle(0, 50);

    // Back-to-back frames with valid held high throughout.
    frame(0, 8'h00, 0, 1'b1, 8'hFF, 1'b0, 0);
    frame(0, 8'hFF, 0, 1'b0, 8'h00, 1'b1, 0);
    idle(0, 2);

    // Reset during data bit 3 aborts the frame.
    frame(0, 8'hC3, 0, 1'b0, 8'h00, 1'b0, 4 * CPB + 2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_txd",   0, 8'(txd[0]),       8'd1);
    chk("abort_busy",  0, 8'(busy[0]),      8'd0);
    chk("abort_done",  0, 8'(done[0]),      8'd0);
    chk("abort_sr_q",  0, sr_q[0],          8'hFF);
    chk("abort_ready", 0, 8'(din_ready[0]), 8'd0);
    chk("abort_pin",   0, sr_pin[0],        8'hFF);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_ready", 0, 8'(din_ready[0]), 8'd1);
    chk("release_busy",  0, 8'(busy[0]),      8'd0);
    idle(0, 1);

    // Two stop bits, valid held through START is ignored; parity byte on both senses.
    frame(1, 8'h07, CPB, 1'b0, 8'h00, 1'b0, 0);
    idle(1, 2);
    frame(0, 8'h07, 0, 1'b0, 8'h00, 1'b0, 0);
    idle(0, 2);

    // Randomized frames, gaps, chaining and ignored valids.
    for (int d = 0; d < 2; d++) begin
      pre = 1'b0;
      b   = 8'($urandom);
      for (int i = 0; i < 12; i++) begin
        ch   = (i != 11) && ($urandom_range(0, 1) == 1);
        nb   = 8'($urandom);
        hold = ch ? 0 : int'($urandom_range(0, 2 * CPB));
        frame(d, b, hold, ch, nb, pre, 0);
        if (!ch) idle(d, int'($urandom_range(1, 4)));
        pre = ch;
        b   = nb;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
